// File: rtl/mpu_reg_responder.sv
// Register-file responder for MPU multiply requests. It latches the operands and
// destination, checks them against read/write lock scoreboards, and grants dispatch.
module mpu_reg_responder #(
  parameter int MATRIX_REGISTERS = 8,
  parameter int MATRIX_REG_BITS  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reg_collector_req_in,
  input  logic                        reg_disp_req_in,
  input  logic [MATRIX_REG_BITS:0]    reg_src_addr_0_in,
  input  logic [MATRIX_REG_BITS:0]    reg_src_addr_1_in,
  input  logic [MATRIX_REG_BITS:0]    reg_dest_addr_in,
  input  logic                        disp_done_in,
  input  logic                        collector_done_in,
  input  logic [MATRIX_REG_BITS:0]    collector_done_addr_in,
  output logic                        reg_collector_ready_out,
  output logic                        reg_disp_ready_out,
  output logic [MATRIX_REGISTERS-1:0] reg_busy_out,
  output logic                        lock_err_out
);

  localparam int AW = MATRIX_REG_BITS + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    GRANT     = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t                      state;
  logic [AW-1:0]               src0;
  logic [AW-1:0]               src1;
  logic [AW-1:0]               dest;
  logic [MATRIX_REGISTERS-1:0] read_lock;
  logic [MATRIX_REGISTERS-1:0] write_lock;

  logic                        both_req;
  logic                        dest_conflict;
  logic                        hazard_free;
  logic                        grant;
  logic                        check_err;
  logic                        rel_err;
  logic [MATRIX_REGISTERS-1:0] src_mask;
  logic [MATRIX_REGISTERS-1:0] dest_mask;
  logic [MATRIX_REGISTERS-1:0] done_mask;
  logic [MATRIX_REGISTERS-1:0] read_lock_nxt;
  logic [MATRIX_REGISTERS-1:0] write_lock_nxt;

  function automatic logic [MATRIX_REGISTERS-1:0] onehot(input logic [AW-1:0] a);
    logic [MATRIX_REGISTERS-1:0] m;
    for (int i = 0; i < MATRIX_REGISTERS; i++) begin
      m[i] = (a == AW'(i));
    end
    return m;
  endfunction

  // Hazard evaluation and scoreboard next-state, all from registered state
  always_comb begin
    both_req      = reg_collector_req_in & reg_disp_req_in;
    dest_conflict = (dest == src0) || (dest == src1);
    src_mask      = onehot(src0) | onehot(src1);
    dest_mask     = onehot(dest);
    done_mask     = collector_done_in ? onehot(collector_done_addr_in) : '0;
    hazard_free   = (read_lock == '0) && ((write_lock & (src_mask | dest_mask)) == '0);
    check_err     = (state == CHECK) && both_req && dest_conflict;
    grant         = (state == CHECK) && both_req && !dest_conflict && hazard_free;
    rel_err       = (disp_done_in && (read_lock == '0)) ||
                    (collector_done_in && ((write_lock & done_mask) == '0));
    // A grant only happens with read_lock clear, so clear-then-set is safe
    read_lock_nxt  = (disp_done_in ? '0 : read_lock) | (grant ? src_mask : '0);
    write_lock_nxt = (write_lock & ~done_mask) | (grant ? dest_mask : '0);
  end

  // Request FSM, scoreboard and registered handshake/error outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= IDLE;
      src0                    <= '0;
      src1                    <= '0;
      dest                    <= '0;
      read_lock               <= '0;
      write_lock              <= '0;
      reg_collector_ready_out <= 1'b0;
      reg_disp_ready_out      <= 1'b0;
      lock_err_out            <= 1'b0;
    end else begin
      read_lock               <= read_lock_nxt;
      write_lock              <= write_lock_nxt;
      reg_collector_ready_out <= grant;
      reg_disp_ready_out      <= grant;
      lock_err_out            <= check_err | rel_err;
      case (state)
        IDLE: begin
          if (both_req) begin
            src0  <= reg_src_addr_0_in;
            src1  <= reg_src_addr_1_in;
            dest  <= reg_dest_addr_in;
            state <= CHECK;
          end else begin
            state <= IDLE;
          end
        end
        CHECK: begin
          if (!both_req) begin
            state <= IDLE;
          end else if (dest_conflict) begin
            state <= WAIT_DROP;
          end else if (hazard_free) begin
            state <= GRANT;
          end else begin
            state <= CHECK;
          end
        end
        GRANT: begin
          state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          // Holding off until the controller drops both requests avoids a double grant
          if (!reg_collector_req_in && !reg_disp_req_in) begin
            state <= IDLE;
          end else begin
            state <= WAIT_DROP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign reg_busy_out = read_lock | write_lock;

endmodule

// File: doc/mpu_reg_responder.md
Name: mpu_reg_responder

Overview:
Register-file-side responder for the MPU controller's collector/dispatcher request interface. It latches the operand and destination addresses of a multiply request and checks them against a lock scoreboard covering read-after-write, write-after-write and in-flight dispatch hazards. Once the request is hazard-free it returns the ready handshake that lets the controller start dispatch. It sits inside the matrix register file, between the MPU controller and the register storage.

Parameters:
MATRIX_REGISTERS, 8, number of matrix registers; also the width of the scoreboard.
MATRIX_REG_BITS, 2, MSB index of register addresses, so addresses are MATRIX_REG_BITS+1 bits wide.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
reg_collector_req_in  in  1  collector write request, held high by the controller for the whole multiply start
reg_disp_req_in  in  1  dispatcher load request, held high alongside the collector request
reg_src_addr_0_in  in  MATRIX_REG_BITS+1  multiplicand register address
reg_src_addr_1_in  in  MATRIX_REG_BITS+1  multiplier register address
reg_dest_addr_in  in  MATRIX_REG_BITS+1  destination register address
disp_done_in  in  1  one-cycle pulse: dispatcher has finished reading both sources
collector_done_in  in  1  one-cycle pulse: collector has finished writing a result
collector_done_addr_in  in  MATRIX_REG_BITS+1  register written by that collector
reg_collector_ready_out  out  1  collector store granted (registered)
reg_disp_ready_out  out  1  dispatcher load granted (registered)
reg_busy_out  out  MATRIX_REGISTERS  per-register OR of read lock and write lock
lock_err_out  out  1  one-cycle protocol or hazard error pulse

Behaviour:
- Reset: rst low clears everything asynchronously, whatever the current state.
  - FSM goes to IDLE.
  - Both ready outputs, lock_err_out, reg_busy_out and every read/write lock bit go to 0.
- Scoreboard state:
  - read_lock[MATRIX_REGISTERS]: set on both sources of the dispatch in flight. At most one dispatch is in flight.
  - write_lock[MATRIX_REGISTERS]: any number of outstanding collector writes.
- FSM states: IDLE, CHECK, GRANT, WAIT_DROP.
- IDLE:
  - When both request inputs are high at a clock edge, latch src0, src1 and dest, then go to CHECK.
  - If only one request is high, stay in IDLE; this is not an error.
- CHECK evaluates the registered scoreboard only; lock changes made on the same edge are seen one cycle later.
  - Error: if dest equals src0 or src1, pulse lock_err_out for 1 cycle, set no locks, go to WAIT_DROP.
  - Grant: if no read lock is set anywhere, write_lock[src0]=0, write_lock[src1]=0 and write_lock[dest]=0:
    - set read_lock[src0], read_lock[src1] (the same bit if the sources are equal) and write_lock[dest];
    - drive both ready outputs high on this edge;
    - go to GRANT.
  - Stall: otherwise remain in CHECK and re-evaluate every cycle.
  - Abort: if either request input drops while in CHECK, go to IDLE with no locks set and no error.
- GRANT:
  - Both ready outputs are high for exactly this one cycle.
  - Next state is WAIT_DROP, and both readies return to 0.
- WAIT_DROP: stay until both request inputs are low, then go to IDLE. This prevents a double grant while the controller is still holding its request.
- Latency: requests first high at edge 0 give ready high in the cycle after edge 1, i.e. 2 clocks, when there is no hazard.
- Lock release:
  - disp_done_in clears all read_lock bits.
  - collector_done_in clears write_lock[collector_done_addr_in].
- Release errors (lock_err_out pulses, state unchanged):
  - disp_done_in while no read lock is set;
  - collector_done_in to a register that is not write-locked.
- Simultaneous events:
  - Release pulses are honoured in any FSM state.
  - If a release and a grant land on the same edge, both take effect.
  - The grant cannot collide with a release of its own dest, because a write-locked dest blocks the grant.
  - lock_err_out is the OR of all error sources in that cycle.
- reg_busy_out = read_lock | write_lock, taken from registered state.

Test Plan:
- Reset then request src0=1, src1=2, dest=3 with both reqs high at edge 0 -> both readies high for exactly 1 cycle after edge 1; reg_busy_out=8'h0E.
- From that state, hold reqs high for 5 more cycles -> no second ready pulse. Drop reqs, then raise a new request src0=4, src1=5, dest=6 -> stays in CHECK until disp_done_in; ready follows 1 cycle after the release.
- RAW: write_lock[3] still set, request src0=3, src1=0, dest=7 -> no ready. collector_done_in with addr=3 -> ready 1 cycle later; busy bit 3 clears.
- dest=src1=2 -> lock_err_out 1-cycle pulse, no ready, reg_busy_out unchanged.
- Spurious disp_done_in with no read locks, and collector_done_in addr=5 when bit 5 is unlocked -> lock_err_out pulses; scoreboard unchanged.
- Assert rst low while in GRANT with locks set -> readies, reg_busy_out and lock_err_out are 0 immediately (asynchronous); FSM is in IDLE after release.
